// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine over a 128-bit state.
// COLS_PER_CYCLE mixer lanes are reused across the four columns.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int         LANES    = COLS_PER_CYCLE;
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_fsm;
  state_t                 w_fsm_next;
  logic [1:0]             r_col_idx;
  logic                   r_inv;
  // Column 0 lives in r_cols[3] so the packed array lines up with the 128-bit port.
  logic [3:0][31:0]       r_cols;
  logic [LANES-1:0][1:0]  w_lane_col;
  logic [LANES-1:0][31:0] w_lane_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]       a, x2, x4, x8;
    logic [3:0][7:0]  k0, k1, k2, k3;
    logic [31:0]      res;
    k0 = '0; k1 = '0; k2 = '0; k3 = '0;
    for (int j = 0; j < 4; j++) begin
      a  = col[31-8*j -: 8];
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      if (!inv) begin
        k0[j] = x2;
        k1[j] = x2 ^ a;
        k2[j] = a;
        k3[j] = a;
      end else begin
        k0[j] = x8 ^ x4 ^ x2;
        k1[j] = x8 ^ x2 ^ a;
        k2[j] = x8 ^ x4 ^ a;
        k3[j] = x8 ^ a;
      end
    end
    res = '0;
    // Output byte i takes coefficient position (j - i) mod 4 from source byte j.
    for (int i = 0; i < 4; i++) begin
      res[31-8*i -: 8] = k0[i] ^ k1[(i+1)%4] ^ k2[(i+2)%4] ^ k3[(i+3)%4];
    end
    return res;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_col[gi] = r_col_idx + 2'(gi);
      assign w_lane_out[gi] = mix_col(r_cols[2'd3 - w_lane_col[gi]], r_inv);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE: if (in_valid)                w_fsm_next = S_RUN;
      S_RUN:  if (r_col_idx == LAST_IDX)   w_fsm_next = S_DONE;
      S_DONE: if (out_ready)               w_fsm_next = S_IDLE;
      default:                             w_fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_idx <= 2'd0;
      r_inv     <= 1'b0;
      r_cols    <= '0;
    end else if (r_fsm == S_IDLE && in_valid) begin
      r_col_idx <= 2'd0;
      r_inv     <= in_inv;
      r_cols    <= in_state;
    end else if (r_fsm == S_RUN) begin
      r_col_idx <= r_col_idx + STEP;
      for (int l = 0; l < LANES; l++) begin
        r_cols[2'd3 - w_lane_col[l]] <= w_lane_out[l];
      end
    end
  end

  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm == S_RUN) || (r_fsm == S_DONE);
  assign out_state = r_cols;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances (1, 2 and 4 columns per cycle)
// checked against hand-computed AES MixColumns vectors.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_inv;
  logic [127:0] in_state;
  logic         iv  [3];
  logic         orr [3];
  logic         ir  [3];
  logic         ov  [3];
  logic         bz  [3];
  logic [127:0] os  [3];

  int n_assert = 0;
  int n_fail   = 0;

  logic [127:0] vin  [8];
  logic [127:0] vexp [8];
  logic         vinv [8];

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_inv(in_inv),
    .in_state(in_state), .out_valid(ov[0]), .out_ready(orr[0]), .out_state(os[0]), .busy(bz[0]));
  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_inv(in_inv),
    .in_state(in_state), .out_valid(ov[1]), .out_ready(orr[1]), .out_state(os[1]), .busy(bz[1]));
  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_inv(in_inv),
    .in_state(in_state), .out_valid(ov[2]), .out_ready(orr[2]), .out_state(os[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ov[k] !== 1'b1 && lat < 20);
  endtask

  task automatic run_txn(input int k, input logic [127:0] st, input logic inv,
                         input logic [127:0] exp, input int exp_lat, input string tag);
    int lat;
    chk({tag, "_in_ready"}, 128'(ir[k]), 128'd1);
    in_state = st;
    in_inv   = inv;
    iv[k]    = 1'b1;
    @(posedge clk); #1;
    iv[k]    = 1'b0;
    in_inv   = ~inv;
    in_state = {4{32'hdeadbeef}};
    chk({tag, "_busy"}, 128'(bz[k]), 128'd1);
    wait_valid(k, lat);
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_result"}, os[k], exp);
    orr[k] = 1'b1;
    @(posedge clk); #1;
    orr[k] = 1'b0;
    chk({tag, "_valid_drop"}, 128'(ov[k]), 128'd0);
    chk({tag, "_ready_back"}, 128'(ir[k]), 128'd1);
    $display("txn %s: in=%h inv=%0d out=%h latency=%0d", tag, st, inv, os[k], lat);
  endtask

  initial begin
    int lat;
    vin[0] = {4{32'hdb135345}};                        vinv[0] = 1'b0; vexp[0] = {4{32'h8e4da1bc}};
    vin[1] = {4{32'h8e4da1bc}};                        vinv[1] = 1'b1; vexp[1] = {4{32'hdb135345}};
    vin[2] = 128'h01010101c6c6c6c601010101c6c6c6c6;    vinv[2] = 1'b0; vexp[2] = vin[2];
    vin[3] = 128'h01010101c6c6c6c601010101c6c6c6c6;    vinv[3] = 1'b1; vexp[3] = vin[3];
    vin[4] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;    vinv[4] = 1'b0; vexp[4] = 128'h046681e5e0cb199a48f8d37a2806264c;
    vin[5] = 128'h046681e5e0cb199a48f8d37a2806264c;    vinv[5] = 1'b1; vexp[5] = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    vin[6] = 128'hdb135345f20a225cc6c6c6c6d4bf5d30;    vinv[6] = 1'b0; vexp[6] = 128'h8e4da1bc9fdc589dc6c6c6c6046681e5;
    vin[7] = 128'h8e4da1bc9fdc589dc6c6c6c6046681e5;    vinv[7] = 1'b1; vexp[7] = 128'hdb135345f20a225cc6c6c6c6d4bf5d30;

    rst = 1'b1;
    in_inv = 1'b0;
    in_state = '0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      orr[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset%0d_in_ready", k), 128'(ir[k]), 128'd1);
      chk($sformatf("reset%0d_out_valid", k), 128'(ov[k]), 128'd0);
      chk($sformatf("reset%0d_busy", k), 128'(bz[k]), 128'd0);
      chk($sformatf("reset%0d_out_state", k), os[k], 128'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table on every lane configuration; in_inv is flipped after each accept.
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 8; v++) begin
        run_txn(k, vin[v], vinv[v], vexp[v], 4 >> k, $sformatf("cpc%0d_v%0d", 1 << k, v));
      end
    end

    // Backpressure on the one-column instance, with a competing in_valid during DONE.
    in_state = vin[4];
    in_inv   = 1'b0;
    iv[0]    = 1'b1;
    @(posedge clk); #1;
    in_state = vin[0];
    in_inv   = 1'b1;
    wait_valid(0, lat);
    chk("bp_latency", 128'(lat), 128'd4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_state", c), os[0], vexp[4]);
      chk($sformatf("bp_hold%0d_valid", c), 128'(ov[0]), 128'd1);
      chk($sformatf("bp_hold%0d_in_ready", c), 128'(ir[0]), 128'd0);
    end
    iv[0]  = 1'b0;
    orr[0] = 1'b1;
    @(posedge clk); #1;
    orr[0] = 1'b0;
    chk("bp_release_valid", 128'(ov[0]), 128'd0);
    chk("bp_release_in_ready", 128'(ir[0]), 128'd1);
    @(posedge clk); #1;
    chk("bp_idle_busy", 128'(bz[0]), 128'd0);
    $display("txn bp: held 10 cycles, out=%h", vexp[4]);

    // Reset two cycles into RUN.
    in_state = vin[6];
    in_inv   = 1'b0;
    iv[0]    = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_run_in_ready", 128'(ir[0]), 128'd1);
    chk("rst_run_out_valid", 128'(ov[0]), 128'd0);
    chk("rst_run_busy", 128'(bz[0]), 128'd0);
    chk("rst_run_out_state", os[0], 128'd0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_run_no_valid", 128'(ov[0]), 128'd0);
    end
    $display("txn rst_run: transaction discarded");
    run_txn(0, vin[4], 1'b0, vexp[4], 4, "after_rst_fwd");

    // Reset while stalled in DONE on the four-column instance.
    in_state = vin[0];
    in_inv   = 1'b0;
    iv[2]    = 1'b1;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    wait_valid(2, lat);
    chk("rst_done_latency", 128'(lat), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_done_out_valid", 128'(ov[2]), 128'd0);
    chk("rst_done_out_state", os[2], 128'd0);
    chk("rst_done_in_ready", 128'(ir[2]), 128'd1);
    $display("txn rst_done: stalled result discarded");
    run_txn(2, vin[7], 1'b1, vexp[7], 1, "after_rst_inv");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
